// File: rtl/sel_enc_b_t_s.sv
// Binary-to-temporal select encoder: a 2-deep index FIFO feeds one slot per gamma cycle,
// and the slot is emitted as an edge position on select_line. Define SEL_ENC_PULSE_EN for pulse coding.
module sel_enc_b_t_s #(
   parameter  int GAMMA_CYCLE_WIDTH = 16,
   parameter  int PULSE_WIDTH       = 8,
   localparam int VAL_W             = $clog2(GAMMA_CYCLE_WIDTH)
) (
   input  logic             aclk,
   input  logic             grst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [VAL_W-1:0] in_value,
   output logic             select_line,
   output logic             gamma_start,
   output logic [VAL_W-1:0] gamma_count
);

`ifdef SEL_ENC_PULSE_EN
   localparam bit PULSE_MODE = 1'b1;
`else
   localparam bit PULSE_MODE = 1'b0;
`endif

   localparam logic [VAL_W-1:0] K_LAST    = VAL_W'(GAMMA_CYCLE_WIDTH - 1);
   // Step coding is a pulse that can never end inside the gamma cycle.
   localparam int unsigned      HIGH_SPAN = PULSE_MODE ? PULSE_WIDTH : GAMMA_CYCLE_WIDTH;

   logic [VAL_W-1:0] k_q, k_d;
   logic [VAL_W-1:0] fifo_q [2];
   logic [VAL_W-1:0] fifo_d [2];
   logic [1:0]       cnt_q, cnt_d;
   logic             slot_v_q, slot_v_d;
   logic [VAL_W-1:0] slot_val_q, slot_val_d;
   logic             sel_q, sel_d;
   logic             wrap, push, pop;
   logic [31:0]      k_ext, val_ext;

   assign wrap     = (k_q == K_LAST);
   assign in_ready = !grst && (cnt_q != 2'd2);
   assign push     = in_valid && in_ready;
   assign pop      = wrap && (cnt_q != 2'd0);

   always_comb begin
      k_d        = wrap ? '0 : k_q + VAL_W'(1);
      fifo_d     = fifo_q;
      cnt_d      = cnt_q;
      slot_v_d   = slot_v_q;
      slot_val_d = slot_val_q;
      if (wrap) begin
         slot_v_d = pop;
         if (pop) slot_val_d = fifo_q[0];
      end
      // Pop is resolved first so a same-edge push lands behind the surviving entries.
      if (pop) begin
         fifo_d[0] = fifo_q[1];
         cnt_d     = cnt_q - 2'd1;
      end
      if (push) begin
         fifo_d[cnt_d[0]] = in_value;
         cnt_d            = cnt_d + 2'd1;
      end
      // Line for the cycle being entered, so the output is a plain flop.
      k_ext   = 32'(k_d);
      val_ext = 32'(slot_val_d);
      sel_d   = slot_v_d
             && (val_ext < 32'(GAMMA_CYCLE_WIDTH))
             && (k_ext >= val_ext)
             && (k_ext < val_ext + 32'(HIGH_SPAN));
   end

   always_ff @(posedge aclk) begin
      if (grst) begin
         k_q        <= '0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         cnt_q      <= '0;
         slot_v_q   <= 1'b0;
         slot_val_q <= '0;
         sel_q      <= 1'b0;
      end else begin
         k_q        <= k_d;
         fifo_q[0]  <= fifo_d[0];
         fifo_q[1]  <= fifo_d[1];
         cnt_q      <= cnt_d;
         slot_v_q   <= slot_v_d;
         slot_val_q <= slot_val_d;
         sel_q      <= sel_d;
      end
   end

   assign select_line = sel_q;
   assign gamma_start = !grst && (k_q == '0);
   assign gamma_count = k_q;

endmodule

// File: tb/tb_sel_enc_b_t_s.sv
// Directed bench for sel_enc_b_t_s: handshake, latency, FIFO-full, wrap-edge push and reset abort.
module tb_sel_enc_b_t_s;
   localparam int G     = 16;
   localparam int PW    = 8;
   localparam int VAL_W = $clog2(G);

   logic             clk = 1'b0;
   logic             grst;
   logic             in_valid;
   logic             in_ready;
   logic [VAL_W-1:0] in_value;
   logic             select_line;
   logic             gamma_start;
   logic [VAL_W-1:0] gamma_count;

   int n_chk = 0;
   int n_bad = 0;
   int gidx, start_g, start_k;
   int pend[$];
   int acc[$];

   always #5 clk = ~clk;

   sel_enc_b_t_s #(
      .GAMMA_CYCLE_WIDTH(G),
      .PULSE_WIDTH      (PW)
   ) dut (
      .aclk       (clk),
      .grst       (grst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_value   (in_value),
      .select_line(select_line),
      .gamma_start(gamma_start),
      .gamma_count(gamma_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // End (exclusive) of the high window for an index starting at lo.
   function automatic int hi_of(input int lo);
`ifdef SEL_ENC_PULSE_EN
      return (lo + PW < G) ? lo + PW : G;
`else
      return G;
`endif
   endfunction

   task automatic do_reset(input string tag);
      grst     = 1'b1;
      in_valid = 1'b0;
      in_value = '0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk({tag, "_rst_sel"}, select_line, 0);
         chk({tag, "_rst_rdy"}, in_ready, 0);
         chk({tag, "_rst_gs"},  gamma_start, 0);
         chk({tag, "_rst_cnt"}, gamma_count, 0);
      end
      grst    = 1'b0;
      gidx    = 0;
      start_g = 0;
      start_k = 0;
      pend.delete();
      acc.delete();
   endtask

   // Runs ncyc cycles of the current gamma, expecting the line high for lo <= k < hi.
   task automatic run_gamma(input int lo, input int hi, input string tag, input int ncyc = G);
      for (int k = 0; k < ncyc; k++) begin
         in_valid = (pend.size() > 0) && ((gidx > start_g) || (gidx == start_g && k >= start_k));
         in_value = in_valid ? VAL_W'(pend[0]) : '0;
         #1;
         chk({tag, "_cnt"}, gamma_count, k);
         chk({tag, "_gs"},  gamma_start, (k == 0));
         chk({tag, "_sel"}, select_line, (k >= lo && k < hi));
         if (in_valid && in_ready) begin
            acc.push_back(gidx * 100 + k);
            void'(pend.pop_front());
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (ncyc == G) gidx++;
   endtask

   initial begin
      grst     = 1'b1;
      in_valid = 1'b0;
      in_value = '0;

      // Single index, pushed mid-gamma
      do_reset("t1");
      start_k = 3;
      pend.push_back(10);
      run_gamma(0, 0, "t1g0");
      run_gamma(10, hi_of(10), "t1g1");
      run_gamma(0, 0, "t1g2");
      chk("t1_nacc", acc.size(), 1);
      chk("t1_acc0", acc[0], 3);

      // Extremes 0 and G-1
      do_reset("t2");
      pend.push_back(0);
      pend.push_back(15);
      run_gamma(0, 0, "t2g0");
      run_gamma(0, hi_of(0), "t2g1");
      run_gamma(15, hi_of(15), "t2g2");
      run_gamma(0, 0, "t2g3");

      // Back-pressure with valid held: third value waits for the pop
      do_reset("t3");
      start_k = 1;
      pend.push_back(3);
      pend.push_back(7);
      pend.push_back(9);
      run_gamma(0, 0, "t3g0");
      run_gamma(3, hi_of(3), "t3g1");
      run_gamma(7, hi_of(7), "t3g2");
      run_gamma(9, hi_of(9), "t3g3");
      run_gamma(0, 0, "t3g4");
      chk("t3_nacc", acc.size(), 3);
      chk("t3_acc0", acc[0], 1);
      chk("t3_acc1", acc[1], 2);
      chk("t3_acc2", acc[2], 100);

      // Push on the wrap edge does not bypass into the slot
      do_reset("t4");
      start_k = 15;
      pend.push_back(5);
      run_gamma(0, 0, "t4g0");
      run_gamma(0, 0, "t4g1");
      run_gamma(5, hi_of(5), "t4g2");
      chk("t4_acc0", acc[0], 15);

      // Reset mid-gamma while the line is high
      do_reset("t5");
      pend.push_back(4);
      run_gamma(0, 0, "t5g0");
      run_gamma(4, hi_of(4), "t5g1", 13);
      do_reset("t5b");
      #1;
      chk("t5_rdy_after", in_ready, 1);
      run_gamma(0, 0, "t5p0");
      run_gamma(0, 0, "t5p1");

      // Pulse-width boundaries (step-coded when the pulse option is off)
      do_reset("t6");
      pend.push_back(2);
      pend.push_back(10);
      run_gamma(0, 0, "t6g0");
      run_gamma(2, hi_of(2), "t6g1");
      run_gamma(10, hi_of(10), "t6g2");
      run_gamma(0, 0, "t6g3");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
